// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg
// Shared types and constants for the UART command parser and its response
// sender: the FSM state encoding, command codes, default framing bytes and
// the frame checksum helper.
package uart_cmd_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_GET_CMD,
        ST_GET_ADDR,
        ST_GET_DATA,
        ST_GET_SUM,
        ST_EXEC,
        ST_RD_WAIT,
        ST_SEND_A,
        ST_SEND_A_WAIT,
        ST_SEND_B,
        ST_SEND_B_WAIT
    } state_t;

    localparam logic [7:0] CMD_WRITE   = 8'h01;
    localparam logic [7:0] CMD_READ    = 8'h02;
    localparam logic [7:0] DEF_HEADER  = 8'h55;
    localparam logic [7:0] DEF_ACK     = 8'h06;
    localparam logic [7:0] DEF_NAK     = 8'h15;

    // 8-bit wrapping sum of the three payload bytes.
    function automatic logic [7:0] frame_sum(input logic [7:0] cmd,
                                             input logic [7:0] addr,
                                             input logic [7:0] data);
        return cmd + addr + data;
    endfunction

endpackage

// File: rtl/uart_resp_sender.sv
// uart_resp_sender
// Transmits a 1- or 2-byte response over the UART send handshake.
// A start pulse (accepted only when idle) latches byte_a, byte_b and
// two_bytes. Each byte is offered with a one-cycle send_req while
// send_ready is high; the sender then waits for send_ready to drop and
// return high before moving on. done pulses for one cycle on completion.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               one-cycle request to send a response
//   byte_a, byte_b      first / optional second response byte
//   two_bytes           1 = send byte_b after byte_a
//   send_ready          transmitter idle
//   send_data, send_req byte and one-cycle request to the transmitter
//   done                one-cycle pulse when the response is complete
module uart_resp_sender
    import uart_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] byte_a,
    input  logic [7:0] byte_b,
    input  logic       two_bytes,
    input  logic       send_ready,
    output logic [7:0] send_data,
    output logic       send_req,
    output logic       done
);

    state_t     state_q, state_d;
    logic [7:0] byte_a_q, byte_a_d;
    logic [7:0] byte_b_q, byte_b_d;
    logic       two_q, two_d;
    logic       seen_low_q, seen_low_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            byte_a_q   <= 8'h00;
            byte_b_q   <= 8'h00;
            two_q      <= 1'b0;
            seen_low_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_a_q   <= byte_a_d;
            byte_b_q   <= byte_b_d;
            two_q      <= two_d;
            seen_low_q <= seen_low_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_a_d   = byte_a_q;
        byte_b_d   = byte_b_q;
        two_d      = two_q;
        seen_low_d = seen_low_q;
        send_data  = 8'h00;
        send_req   = 1'b0;
        done       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    byte_a_d = byte_a;
                    byte_b_d = byte_b;
                    two_d    = two_bytes;
                    state_d  = ST_SEND_A;
                end
            end
            ST_SEND_A: begin
                if (send_ready) begin
                    send_data  = byte_a_q;
                    send_req   = 1'b1;
                    seen_low_d = 1'b0;
                    state_d    = ST_SEND_A_WAIT;
                end
            end
            ST_SEND_A_WAIT: begin
                // The byte is only considered taken once ready has gone
                // low and come back high.
                if (seen_low_q && send_ready) begin
                    seen_low_d = 1'b0;
                    if (two_q) begin
                        state_d = ST_SEND_B;
                    end else begin
                        state_d = ST_IDLE;
                        done    = 1'b1;
                    end
                end else if (!send_ready) begin
                    seen_low_d = 1'b1;
                end
            end
            ST_SEND_B: begin
                if (send_ready) begin
                    send_data  = byte_b_q;
                    send_req   = 1'b1;
                    seen_low_d = 1'b0;
                    state_d    = ST_SEND_B_WAIT;
                end
            end
            ST_SEND_B_WAIT: begin
                if (seen_low_q && send_ready) begin
                    seen_low_d = 1'b0;
                    state_d    = ST_IDLE;
                    done       = 1'b1;
                end else if (!send_ready) begin
                    seen_low_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
// Assembles 5-byte frames (HEADER, CMD, ADDR, DATA, SUM) from the UART
// receiver, validates the checksum, issues register write/read strobes and
// returns ACK / ACK+data / NAK through uart_resp_sender.
// Optional: define UART_CMD_TIMEOUT_EN to abort a partial frame after
// TIMEOUT_CYCLES idle cycles (frame_err pulse, no response).
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   recv_data, recv_valid           received byte stream
//   send_data, send_req, send_ready transmit handshake
//   reg_addr, reg_wdata             latched register address / write data
//   reg_wr, reg_rd                  one-cycle register strobes
//   reg_rdata                       read data, valid the cycle after reg_rd
//   frame_err                       one-cycle error pulse
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0]  HEADER         = DEF_HEADER,
    parameter logic [7:0]  ACK_BYTE       = DEF_ACK,
    parameter logic [7:0]  NAK_BYTE       = DEF_NAK,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] recv_data,
    input  logic       recv_valid,
    output logic [7:0] send_data,
    output logic       send_req,
    input  logic       send_ready,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr,
    output logic       reg_rd,
    input  logic [7:0] reg_rdata,
    output logic       frame_err
);

    state_t     state_q, state_d;
    logic [7:0] cmd_q, cmd_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] sum_q, sum_d;

    logic       resp_start;
    logic [7:0] resp_a;
    logic [7:0] resp_b;
    logic       resp_two;
    logic       resp_done;
    logic       in_frame;
    logic       timeout_hit;

    assign in_frame  = (state_q == ST_GET_CMD)  || (state_q == ST_GET_ADDR) ||
                       (state_q == ST_GET_DATA) || (state_q == ST_GET_SUM);
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;

`ifdef UART_CMD_TIMEOUT_EN
    localparam int unsigned      CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts idle cycles inside a frame; a received byte always wins over
    // expiry in the same cycle because it clears the count.
    always_comb begin
        cnt_d = cnt_q;
        if (recv_valid || !in_frame) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_hit = in_frame && !recv_valid && (cnt_q == CNT_MAX);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cmd_q   <= 8'h00;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            sum_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sum_q   <= sum_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        sum_d      = sum_q;
        reg_wr     = 1'b0;
        reg_rd     = 1'b0;
        frame_err  = 1'b0;
        resp_start = 1'b0;
        resp_a     = ACK_BYTE;
        resp_b     = 8'h00;
        resp_two   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (recv_valid && (recv_data == HEADER)) state_d = ST_GET_CMD;
            end
            ST_GET_CMD: begin
                if (recv_valid) begin
                    cmd_d   = recv_data;
                    state_d = ST_GET_ADDR;
                end
            end
            ST_GET_ADDR: begin
                if (recv_valid) begin
                    addr_d  = recv_data;
                    state_d = ST_GET_DATA;
                end
            end
            ST_GET_DATA: begin
                if (recv_valid) begin
                    wdata_d = recv_data;
                    state_d = ST_GET_SUM;
                end
            end
            ST_GET_SUM: begin
                if (recv_valid) begin
                    sum_d   = recv_data;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (frame_sum(cmd_q, addr_q, wdata_q) != sum_q) begin
                    frame_err  = 1'b1;
                    resp_a     = NAK_BYTE;
                    resp_start = 1'b1;
                    state_d    = ST_SEND_A;
                end else if (cmd_q == CMD_WRITE) begin
                    reg_wr     = 1'b1;
                    resp_start = 1'b1;
                    state_d    = ST_SEND_A;
                end else if (cmd_q == CMD_READ) begin
                    reg_rd  = 1'b1;
                    state_d = ST_RD_WAIT;
                end else begin
                    frame_err  = 1'b1;
                    resp_a     = NAK_BYTE;
                    resp_start = 1'b1;
                    state_d    = ST_SEND_A;
                end
            end
            ST_RD_WAIT: begin
                // reg_rdata is valid this cycle; the sender latches it.
                resp_b     = reg_rdata;
                resp_two   = 1'b1;
                resp_start = 1'b1;
                state_d    = ST_SEND_A;
            end
            ST_SEND_A: begin
                // Response handed to the sender; its own FSM walks the
                // SEND_A/SEND_B handshake states until done.
                if (resp_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (timeout_hit) begin
            frame_err = 1'b1;
            state_d   = ST_IDLE;
        end
    end

    uart_resp_sender u_sender (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (resp_start),
        .byte_a     (resp_a),
        .byte_b     (resp_b),
        .two_bytes  (resp_two),
        .send_ready (send_ready),
        .send_data  (send_data),
        .send_req   (send_req),
        .done       (resp_done)
    );

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser
// Directed bench for uart_cmd_parser: drives frames byte by byte, models a
// transmitter that goes busy for a few cycles after each send_req and a
// register file that returns read data the cycle after reg_rd.
module tb_uart_cmd_parser;

`ifdef UART_CMD_TIMEOUT_EN
    localparam int unsigned TO_CYC = 100;
`else
    localparam int unsigned TO_CYC = 1000000;
`endif
    localparam logic [7:0] RD_VAL = 8'h3C;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] recv_data = 8'h00;
    logic       recv_valid = 1'b0;
    logic [7:0] send_data;
    logic       send_req;
    logic       send_ready;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata = 8'hEE;
    logic       frame_err;

    uart_cmd_parser #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .recv_data  (recv_data),
        .recv_valid (recv_valid),
        .send_data  (send_data),
        .send_req   (send_req),
        .send_ready (send_ready),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_wr     (reg_wr),
        .reg_rd     (reg_rd),
        .reg_rdata  (reg_rdata),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    // Event monitor (sampled mid-cycle)
    int         cmp_cnt = 0;
    int         err_cnt = 0;
    int         cyc = 0;
    int         wr_n = 0, rd_n = 0, fe_n = 0, tx_n = 0, viol_n = 0;
    logic [7:0] last_addr = 8'h00, last_wdata = 8'h00;
    logic [7:0] tx_log [64];
    int         tx_cyc [64];
    logic       req_s = 1'b0;
    logic       rd_s = 1'b0;
    int         tx_busy = 0;

    assign send_ready = (tx_busy == 0);

    always @(negedge clk) begin
        req_s = send_req;
        rd_s  = reg_rd;
        if (reg_wr) begin
            wr_n++;
            last_addr  = reg_addr;
            last_wdata = reg_wdata;
        end
        if (reg_rd) rd_n++;
        if (frame_err) fe_n++;
        if (send_req) begin
            if (!send_ready) viol_n++;
            if (tx_n < 64) begin
                tx_log[tx_n] = send_data;
                tx_cyc[tx_n] = cyc;
            end
            tx_n++;
        end
    end

    // Transmitter and register-file responders, updated just after the edge
    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (req_s) tx_busy = 6;
        else if (tx_busy != 0) tx_busy--;
        reg_rdata = rd_s ? RD_VAL : 8'hEE;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cmp_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic put_byte(input logic [7:0] b);
        recv_data  = b;
        recv_valid = 1'b1;
        tick(1);
        recv_valid = 1'b0;
        tick(1);
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] a,
                              input logic [7:0] d, input logic [7:0] s);
        put_byte(8'h55);
        put_byte(c);
        put_byte(a);
        put_byte(d);
        put_byte(s);
    endtask

    // Wait (bounded) until tx_n reaches target, then let the link go idle.
    task automatic wait_tx(input string tag, input int target);
        int k;
        k = 0;
        while (tx_n < target && k < 400) begin
            tick(1);
            k++;
        end
        if (tx_n < target) check_eq({tag, "_wait"}, tx_n, target);
        tick(14);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_out"},
                 {7'd0, send_req, send_data, reg_wr, reg_rd, frame_err, 5'd0, reg_addr},
                 32'd0);
        check_eq({tag, "_wdata"}, reg_wdata, 8'h00);
    endtask

    int wr0, rd0, fe0, tx0;
    task automatic snap();
        wr0 = wr_n; rd0 = rd_n; fe0 = fe_n; tx0 = tx_n;
    endtask

    initial begin
        // Reset
        tick(3);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        tick(2);

        // Write frame
        snap();
        send_frame(8'h01, 8'h10, 8'hA5, 8'hB6);
        wait_tx("wr", tx0 + 1);
        check_eq("wr_count", wr_n - wr0, 1);
        check_eq("wr_addr", last_addr, 8'h10);
        check_eq("wr_data", last_wdata, 8'hA5);
        check_eq("wr_tx_count", tx_n - tx0, 1);
        check_eq("wr_tx_byte", tx_log[tx0], 8'h06);
        check_eq("wr_ferr", fe_n - fe0, 0);
        check_eq("wr_no_rd", rd_n - rd0, 0);
        check_eq("addr_hold", reg_addr, 8'h10);

        // Read frame
        snap();
        send_frame(8'h02, 8'h20, 8'h00, 8'h22);
        wait_tx("rd", tx0 + 2);
        check_eq("rd_count", rd_n - rd0, 1);
        check_eq("rd_no_wr", wr_n - wr0, 0);
        check_eq("rd_tx_count", tx_n - tx0, 2);
        check_eq("rd_tx_ack", tx_log[tx0], 8'h06);
        check_eq("rd_tx_data", tx_log[tx0 + 1], RD_VAL);
        check_eq("rd_gap_ok", 32'((tx_cyc[tx0 + 1] - tx_cyc[tx0]) > 6), 1);
        check_eq("rd_ferr", fe_n - fe0, 0);

        // Bad checksum
        snap();
        send_frame(8'h01, 8'h10, 8'hA5, 8'h00);
        wait_tx("bad", tx0 + 1);
        check_eq("bad_no_wr", wr_n - wr0, 0);
        check_eq("bad_ferr", fe_n - fe0, 1);
        check_eq("bad_tx_count", tx_n - tx0, 1);
        check_eq("bad_tx_byte", tx_log[tx0], 8'h15);

        // Unknown command, valid checksum
        snap();
        send_frame(8'h07, 8'h01, 8'h02, 8'h0A);
        wait_tx("unk", tx0 + 1);
        check_eq("unk_no_strobe", (wr_n - wr0) + (rd_n - rd0), 0);
        check_eq("unk_ferr", fe_n - fe0, 1);
        check_eq("unk_tx_byte", tx_log[tx0], 8'h15);

        // Noise before a frame
        snap();
        put_byte(8'h00);
        put_byte(8'hFF);
        put_byte(8'h12);
        send_frame(8'h01, 8'h33, 8'h44, 8'h78);
        wait_tx("noise", tx0 + 1);
        check_eq("noise_wr", wr_n - wr0, 1);
        check_eq("noise_addr", last_addr, 8'h33);
        check_eq("noise_data", last_wdata, 8'h44);
        check_eq("noise_tx_byte", tx_log[tx0], 8'h06);
        check_eq("noise_ferr", fe_n - fe0, 0);

        // Checksum wraps: 01 + FF + 02 = 0x102 -> 02
        snap();
        send_frame(8'h01, 8'hFF, 8'h02, 8'h02);
        wait_tx("wrap", tx0 + 1);
        check_eq("wrap_wr", wr_n - wr0, 1);
        check_eq("wrap_addr", last_addr, 8'hFF);
        check_eq("wrap_tx_byte", tx_log[tx0], 8'h06);

        // A header byte arriving while responding is dropped
        snap();
        send_frame(8'h01, 8'h40, 8'h01, 8'h42);
        put_byte(8'h55);
        wait_tx("drop", tx0 + 1);
        send_frame(8'h01, 8'h41, 8'h02, 8'h44);
        wait_tx("drop2", tx0 + 2);
        check_eq("drop_wr", wr_n - wr0, 2);
        check_eq("drop_addr", last_addr, 8'h41);
        check_eq("drop_ferr", fe_n - fe0, 0);

        // Reset during SEND_A_WAIT of a read response
        snap();
        send_frame(8'h02, 8'h20, 8'h00, 8'h22);
        begin
            int k;
            k = 0;
            while (tx_n < tx0 + 1 && k < 100) begin
                tick(1);
                k++;
            end
        end
        check_eq("rst_first_tx", tx_n - tx0, 1);
        tick(2);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check_outputs_zero("midsend_rst");
        tick(30);
        check_eq("rst_no_more_tx", tx_n - tx0, 1);
        snap();
        send_frame(8'h01, 8'h10, 8'hA5, 8'hB6);
        wait_tx("post_rst", tx0 + 1);
        check_eq("post_rst_wr", wr_n - wr0, 1);
        check_eq("post_rst_tx", tx_log[tx0], 8'h06);

`ifdef UART_CMD_TIMEOUT_EN
        // Partial frame then stall past the timeout
        snap();
        put_byte(8'h55);
        put_byte(8'h01);
        tick(110);
        check_eq("to_ferr", fe_n - fe0, 1);
        check_eq("to_no_tx", tx_n - tx0, 0);
        check_eq("to_no_wr", wr_n - wr0, 0);
        snap();
        send_frame(8'h01, 8'h44, 8'h55, 8'h9A);
        wait_tx("to_next", tx0 + 1);
        check_eq("to_next_wr", wr_n - wr0, 1);
        check_eq("to_next_addr", last_addr, 8'h44);
`endif

        check_eq("no_ready_violation", viol_n, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
- Sits directly downstream of the UART byte receiver and upstream of its byte transmitter.
- Assembles 5-byte command frames from recv_data/recv_valid and checks their checksum.
- Issues register write/read strobes to the analyzer control register file.
- Returns a 1- or 2-byte response through the UART send_data/send_req/send_ready handshake.

Parameters:
- HEADER, 8'h55: frame sync byte.
- ACK_BYTE, 8'h06: positive response byte.
- NAK_BYTE, 8'h15: negative response byte (bad checksum or unknown command).
- TIMEOUT_CYCLES, 1000000: inter-byte timeout in clk cycles (10 ms at 100 MHz). Must be ≥2.

Ports:
- clk  in  1  system clock (100 MHz)
- rst_n  in  1  reset; synchronous, active-low
- recv_data  in  8  received byte, valid with recv_valid
- recv_valid  in  1  one-cycle pulse per received byte
- send_data  out  8  byte to transmit
- send_req  out  1  one-cycle transmit request
- send_ready  in  1  transmitter idle
- reg_addr  out  8  register address
- reg_wdata  out  8  write data
- reg_wr  out  1  one-cycle write strobe
- reg_rd  out  1  one-cycle read strobe
- reg_rdata  in  8  read data, valid exactly 1 cycle after reg_rd
- frame_err  out  1  one-cycle pulse on checksum error, unknown command, or timeout

Behaviour:
- Reset: one clock, reset is synchronous and active-low. Sampled low on a clk edge:
  - state=IDLE; all outputs 0; send_data=0; timeout counter=0.
  - Reset mid-frame or mid-send aborts without emitting any strobe.
- Frame format: HEADER, CMD, ADDR, DATA, SUM.
  - SUM = (CMD+ADDR+DATA) mod 256, carries discarded.
  - CMD 8'h01 = write; CMD 8'h02 = read (DATA is don't-care but included in SUM).
- States: IDLE, GET_CMD, GET_ADDR, GET_DATA, GET_SUM, EXEC, RD_WAIT, SEND_A, SEND_A_WAIT, SEND_B, SEND_B_WAIT.
- IDLE:
  - recv_valid && recv_data==HEADER -> GET_CMD.
  - Any other byte is discarded.
- GET_CMD..GET_SUM: each recv_valid latches the byte and advances one state.
  - HEADER is not special mid-frame; there is no resync.
- GET_SUM + recv_valid -> EXEC (next cycle).
- EXEC (1 cycle):
  - SUM mismatch -> frame_err=1, response NAK -> SEND_A (single byte).
  - CMD==01 -> reg_wr=1 with latched reg_addr/reg_wdata; response ACK -> SEND_A (single byte).
  - CMD==02 -> reg_rd=1 -> RD_WAIT.
  - Any other CMD -> frame_err=1, NAK single byte. No reg strobe.
- RD_WAIT (1 cycle): capture reg_rdata as second byte; response ACK then data -> SEND_A.
- SEND_x: when send_ready==1, drive send_data and assert send_req for exactly one cycle, then go to SEND_x_WAIT.
- SEND_x_WAIT: wait for send_ready==0 followed by send_ready==1. Then go to SEND_B if a second byte is pending, else IDLE.
- send_req is never asserted while send_ready==0.
- reg_addr/reg_wdata hold their last latched value between frames.
- recv_valid outside IDLE..GET_SUM (during EXEC/RD_WAIT/SEND*) is dropped silently.
- recv_valid and timeout expiry in the same cycle: the byte wins, the counter clears.
- Arithmetic: checksum adder is 8 bits and wraps. Timeout counter is $clog2(TIMEOUT_CYCLES) bits and saturates at expiry.

Optional Feature:
- Macro UART_CMD_TIMEOUT_EN.
- Defined:
  - Counter clears on every recv_valid and increments each cycle in GET_CMD..GET_SUM.
  - On reaching TIMEOUT_CYCLES-1: frame_err pulse, state -> IDLE, no response sent.
- Undefined: counter logic absent; a partial frame waits indefinitely.

Decomposition:
- Package uart_cmd_pkg holds:
  - state enum
  - CMD_WRITE=8'h01, CMD_READ=8'h02
  - default HEADER/ACK/NAK constants
- One natural sub-module, uart_resp_sender:
  - Owns SEND_A/SEND_B and the send_ready handshake.
  - Takes a 1- or 2-byte response with a start pulse and returns done.

Test Plan:
- Write frame 55 01 10 A5 B6 -> exactly one reg_wr with reg_addr=10, reg_wdata=A5; then send_data=06 once; frame_err=0.
- Read frame 55 02 20 00 22, reg_rdata=3C -> reg_rd one cycle; sends 06 then 3C, the second only after send_ready returns high.
- Bad checksum 55 01 10 A5 00 -> no reg_wr; frame_err pulse; sends 15.
- Noise bytes 00 FF 12 before a valid write frame -> ignored; frame executes normally.
- UART_CMD_TIMEOUT_EN, TIMEOUT_CYCLES=100: send 55 01, stall 100 cycles -> frame_err pulse, IDLE, nothing sent; the next full frame works.
- rst_n low for 1 cycle during SEND_A_WAIT -> all outputs 0 next cycle; no further send_req; fresh frame accepted.
